// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands and a carry-in, adds them
// LSB first at one bit per clock, and presents {cout,sum} with a one-cycle done.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // state | meaning
  // IDLE  | waiting for start; operands captured on the accepting edge
  // RUN   | one sum bit produced per edge, LSB first
  // DONE  | sum/cout valid and newly updated; start is ignored here
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] s_msb;
  logic [WIDTH-1:0] sr_shift;

  // Full-adder slice on the current operand LSBs
  always_comb begin
    bit_s    = a_q[0] ^ b_q[0] ^ c_q;
    bit_c    = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    s_msb    = '0;
    s_msb[WIDTH-1] = bit_s;
    sr_shift = (sr_q >> 1) | s_msb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sr_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d  = a_q >> 1;
        b_d  = b_q >> 1;
        c_d  = bit_c;
        sr_d = sr_shift;
        // Terminal count: publish the finished word on the same edge
        if (cnt_q == CNT_LAST) begin
          sum_d   = sr_shift;
          cout_d  = bit_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder (WIDTH=8) against plain a+b+cin.
module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  int n_assert;
  int n_fail;
  logic [7:0] last_sum;
  logic       last_cout;

  serial_adder #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    step();
    check("idle_done", done, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_hold_sum", sum, last_sum);
    check("idle_hold_cout", cout, last_cout);
  endtask

  // One full transaction; noisy=1 scrambles operands and keeps poking start while busy.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input bit noisy);
    logic [8:0] exp;
    int ndone;
    exp = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tc};
    ndone = 0;
    start = 1'b1;
    a = ta;
    b = tb_v;
    cin = tc;
    step();
    check("e0_busy", busy, 1'b1);
    check("e0_done", done, 1'b0);
    check("run_hold_sum", sum, last_sum);
    for (int k = 1; k <= 8; k++) begin
      start = noisy ? 1'($urandom) : 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      step();
      if (done) ndone++;
      check("run_busy", busy, 1'b1);
      check("run_done", done, (k == 8) ? 1'b1 : 1'b0);
    end
    check("sum", sum, exp[7:0]);
    check("cout", cout, exp[8]);
    start = noisy ? 1'b1 : 1'b0;
    step();
    start = 1'b0;
    check("e9_done", done, 1'b0);
    check("e9_busy", busy, 1'b0);
    check("done_count", ndone, 1);
    last_sum = exp[7:0];
    last_cout = exp[8];
  endtask

  initial begin
    logic [8:0] e;
    n_assert = 0;
    n_fail = 0;
    last_sum = 8'h00;
    last_cout = 1'b0;
    rst = 1'b1;
    start = 1'b1;
    a = 8'h5A;
    b = 8'hA5;
    cin = 1'b1;
    #2;
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    step();
    check("rst_start_ignored", busy, 1'b0);
    start = 1'b0;
    rst = 1'b0;
    idle_cycle();

    // Basic add
    run_op(8'h0F, 8'h01, 1'b0, 1'b0);
    idle_cycle();

    // Asynchronous reset between edges clears results immediately
    #3;
    rst = 1'b1;
    #1;
    check("async_sum", sum, 8'h00);
    check("async_cout", cout, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_done", done, 1'b0);
    last_sum = 8'h00;
    last_cout = 1'b0;
    step();
    rst = 1'b0;
    idle_cycle();

    // Overflow cases
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    idle_cycle();

    // Busy lockout: start held high, next acceptance at the first IDLE edge
    start = 1'b1;
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    step();
    check("lock_e0_busy", busy, 1'b1);
    a = 8'hAA;
    b = 8'hAA;
    for (int k = 1; k <= 8; k++) step();
    check("lock_done1", done, 1'b1);
    check("lock_sum1", sum, 8'h46);
    check("lock_cout1", cout, 1'b0);
    step();
    check("lock_e9_busy", busy, 1'b0);
    check("lock_e9_done", done, 1'b0);
    step();
    check("lock_e10_busy", busy, 1'b1);
    start = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    check("lock_done2", done, 1'b1);
    check("lock_sum2", sum, 8'h54);
    check("lock_cout2", cout, 1'b1);
    step();
    last_sum = 8'h54;
    last_cout = 1'b1;
    idle_cycle();

    // Mid-operation reset aborts with no done pulse
    start = 1'b1;
    a = 8'h80;
    b = 8'h80;
    cin = 1'b0;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    #2;
    rst = 1'b1;
    start = 1'b1;
    #1;
    check("abort_sum", sum, 8'h00);
    check("abort_cout", cout, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    last_sum = 8'h00;
    last_cout = 1'b0;
    step();
    check("abort_start_ignored", busy, 1'b0);
    start = 1'b0;
    rst = 1'b0;
    for (int k = 0; k < 10; k++) idle_cycle();
    run_op(8'h80, 8'h80, 1'b0, 1'b0);

    // Random transactions with random gaps and noise on inputs while busy
    for (int i = 0; i < 1000; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) idle_cycle();
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    e = 9'h0FF + 9'h0FF + 9'h001;
    check("final_sum_hold", {cout, sum}, ((i_last() == 1'b1) ? {last_cout, last_sum} : e));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  function automatic logic i_last();
    return 1'b1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, 8, operand and sum width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-high.
REQ-004 Port: start  input  1  request to add; sampled on the rising edge of clk.
REQ-005 Port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: cin  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high in RUN and DONE; start is ignored while high.
REQ-009 Port: done  output  1  one-cycle pulse marking a new valid sum/cout.
REQ-010 Port: sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 Port: cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE, with IDLE as the reset state.
REQ-013 In IDLE, start=1 at an edge (acceptance edge E0) SHALL load a/b into operand shift registers, load cin into the carry flop, clear the bit counter and enter RUN.
REQ-014 In RUN, each edge SHALL compute s=a0^b0^c and c'=a0&b0 | c&(a0^b0) from the operand LSBs and the carry flop.
REQ-015 In RUN, each edge SHALL shift both operand registers right by one, shift s into the MSB of the internal sum shift register, update the carry flop to c' and increment the counter.
REQ-016 Processing SHALL be LSB first, exactly one bit per cycle, with edges E1..EWIDTH processing bits 0..WIDTH-1.
REQ-017 At edge EWIDTH the FSM SHALL enter DONE and copy the completed sum and final carry to the sum and cout outputs on that same edge.
REQ-018 done SHALL be 1 only in DONE, for exactly one cycle (EWIDTH to EWIDTH+1), and the FSM SHALL return to IDLE at EWIDTH+1.
REQ-019 Latency from acceptance to done SHALL be exactly WIDTH cycles; throughput SHALL be one add per WIDTH+2 cycles.
REQ-020 sum and cout SHALL hold their last values until the next DONE entry; operand changes or start activity SHALL NOT affect them.
REQ-021 start in RUN or DONE SHALL be ignored and SHALL NOT be queued; start in DONE is not accepted.
REQ-022 a, b and cin SHALL be don't-care except at the acceptance edge.
REQ-023 The counter SHALL be $clog2(WIDTH+1) bits wide, SHALL terminate at WIDTH-1 and SHALL never wrap.
REQ-024 For WIDTH=1, RUN SHALL last exactly one cycle and the result SHALL still equal a+b+cin.
REQ-025 The result SHALL be exact for all inputs: {cout,sum} = a+b+cin.

Reset
REQ-026 rst=1 SHALL immediately, without waiting for clk, force state=IDLE and busy=0, done=0, sum=0 and cout=0, and clear the operand registers, carry flop and counter.
REQ-027 rst asserted during RUN or DONE SHALL abort the operation with no done pulse; a start after rst is released SHALL operate normally.
REQ-028 While rst=1, start SHALL be ignored.

Verification (WIDTH=8)
REQ-029 Reset: assert rst asynchronously between edges -> sum=0x00, cout=0, busy=0 and done=0 before the next edge.
REQ-030 Basic add: a=0x0F, b=0x01, cin=0, start one cycle -> busy=1 from E0, done=1 only in cycle E8-E9, sum=0x10, cout=0, busy=0 after E9.
REQ-031 Overflow: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 Busy lockout: start a=0x12, b=0x34 and keep start=1 with a=0xAA, b=0xAA through RUN/DONE -> first result sum=0x46, cout=0; next acceptance at first IDLE edge (E10) gives sum=0x54, cout=1.
REQ-033 Mid-op reset: start a=0x80, b=0x80, pulse rst after E4 -> outputs 0, no done; then start a=0x80, b=0x80 -> sum=0x00, cout=1 after 8 cycles.
REQ-034 Random: 1000 random a/b/cin with random start gaps, compared against a+b+cin -> zero mismatches, exactly one done per accepted start.
